// File: rtl/cacheline_burst_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adapter
//   Bridges a cache full-line port (one S_LINE-bit line per request) to a
//   memory burst port moving S_BURST bits per beat (BEATS = S_LINE/S_BURST).
//   Write-backs are serialised out of an internal line buffer; fills are
//   assembled into the same buffer and handed back as one line plus a
//   one-cycle response pulse.
//
// Ports
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   line_i     write-back line, captured when a write is accepted
//   line_o     assembled fill line (meaningful while resp_o=1 after a read)
//   address_i  cache-side line address
//   read_i     fill request, held until resp_o
//   write_i    write-back request, held until resp_o (wins over read_i)
//   resp_o     one-cycle completion pulse
//   burst_i    memory read beat data, valid with resp_i
//   burst_o    memory write beat data
//   address_o  memory address: latched address_i with offset bits cleared
//   read_o     memory burst read request
//   write_o    memory burst write request
//   resp_i     memory per-beat acknowledge
// -----------------------------------------------------------------------------
module cacheline_burst_adapter #(
    parameter int S_LINE   = 256,
    parameter int S_BURST  = 64,
    parameter int S_OFFSET = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [S_LINE-1:0]  line_i,
    output logic [S_LINE-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic [S_BURST-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = S_LINE / S_BURST;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Clears the line-offset bits so memory always sees a line-aligned address.
    localparam logic [31:0] OFF_MASK = ~((32'd1 << S_OFFSET) - 32'd1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [S_LINE-1:0]   line_buf_r, line_buf_s;
    logic [31:0]         addr_r, addr_s;

    // State, beat counter, line buffer and latched address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            line_buf_r <= {S_LINE{1'b0}};
            addr_r     <= 32'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            line_buf_r <= line_buf_s;
            addr_r     <= addr_s;
        end
    end

    // Next-state logic: request acceptance, beat sequencing and completion.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        line_buf_s = line_buf_r;
        addr_s     = addr_r;
        case (state_r)
            IDLE: begin
                // Write-back has priority; a simultaneous read must be re-requested.
                if (write_i) begin
                    addr_s     = address_i & OFF_MASK;
                    line_buf_s = line_i;
                    cnt_s      = {CW{1'b0}};
                    state_s    = WR;
                end else if (read_i) begin
                    addr_s  = address_i & OFF_MASK;
                    cnt_s   = {CW{1'b0}};
                    state_s = RD;
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (resp_i) begin
                    line_buf_s[S_BURST*cnt_r +: S_BURST] = burst_i;
                    if (cnt_r == LAST_BEAT) begin
                        cnt_s   = {CW{1'b0}};
                        state_s = DONE;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_s = RD;
                end
            end
            WR: begin
                if (resp_i) begin
                    if (cnt_r == LAST_BEAT) begin
                        cnt_s   = {CW{1'b0}};
                        state_s = DONE;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_s = WR;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Handshake outputs are pure decodes of the state register, so none of
    // them has a combinational path from any input.
    assign read_o    = (state_r == RD);
    assign write_o   = (state_r == WR);
    assign resp_o    = (state_r == DONE);
    assign address_o = addr_r;
    assign line_o    = line_buf_r;
    // Beat data is only driven during a write burst; zero otherwise.
    assign burst_o   = (state_r == WR) ? line_buf_r[S_BURST*cnt_r +: S_BURST]
                                       : {S_BURST{1'b0}};

endmodule
